// File: rtl/dma_bus_master.sv
// Requester side of the HLDR/HLDA bus-hold handshake: after the CPU grants the bus,
// copies a block of bytes with one read and one write cycle per byte, releasing between bursts.
`timescale 1ns/1ps
module dma_bus_master #(
  parameter int unsigned BURST_LEN = 4,
  parameter logic [3:0]  CB_READ   = 4'b1010,
  parameter logic [3:0]  CB_WRITE  = 4'b1001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] src_addr,
  input  logic [7:0] dst_addr,
  input  logic [7:0] count,
  output logic       HLDR,
  input  logic       HLDA,
  inout  wire  [7:0] AB,
  inout  wire  [7:0] DB,
  inout  wire  [3:0] CB,
  output logic       busy,
  output logic       done,
  output logic [7:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_REL  = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] src_q;
  logic [7:0] dst_q;
  logic [7:0] data_q;
  logic [7:0] burst_q;
  logic [7:0] remaining_q;
  logic       hldr_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] ab_q;
  logic [3:0] cb_q;
  logic       ab_oe_q;
  logic       db_oe_q;

  logic [7:0] src_d;
  logic [7:0] dst_d;
  logic [7:0] remaining_d;
  logic [7:0] burst_d;
  logic       burst_full_d;

  // Post-write address/counter values; remaining saturates at zero.
  always_comb begin
    src_d        = src_q + 8'd1;
    dst_d        = dst_q + 8'd1;
    burst_d      = burst_q + 8'd1;
    remaining_d  = (remaining_q != 8'd0) ? (remaining_q - 8'd1) : 8'd0;
    burst_full_d = (BURST_LEN != 32'd0) && (32'(burst_d) >= BURST_LEN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= 8'd0;
      dst_q       <= 8'd0;
      data_q      <= 8'd0;
      burst_q     <= 8'd0;
      remaining_q <= 8'd0;
      hldr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ab_q        <= 8'd0;
      cb_q        <= 4'd0;
      ab_oe_q     <= 1'b0;
      db_oe_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count != 8'd0) begin
              src_q       <= src_addr;
              dst_q       <= dst_addr;
              remaining_q <= count;
              busy_q      <= 1'b1;
              hldr_q      <= 1'b1;
              state_q     <= S_REQ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (HLDA) begin
            burst_q <= 8'd0;
            ab_q    <= src_q;
            cb_q    <= CB_READ;
            ab_oe_q <= 1'b1;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          // A grant lost during the read discards the byte; it is re-read after re-grant.
          if (HLDA) begin
            data_q  <= DB;
            ab_q    <= dst_q;
            cb_q    <= CB_WRITE;
            db_oe_q <= 1'b1;
            state_q <= S_WR;
          end else begin
            ab_oe_q <= 1'b0;
            db_oe_q <= 1'b0;
            hldr_q  <= 1'b0;
            state_q <= S_REL;
          end
        end
        S_WR: begin
          src_q       <= src_d;
          dst_q       <= dst_d;
          remaining_q <= remaining_d;
          burst_q     <= burst_d;
          db_oe_q     <= 1'b0;
          if ((remaining_d == 8'd0) || burst_full_d || !HLDA) begin
            ab_oe_q <= 1'b0;
            hldr_q  <= 1'b0;
            state_q <= S_REL;
          end else begin
            ab_q    <= src_d;
            cb_q    <= CB_READ;
            state_q <= S_RD;
          end
        end
        S_REL: begin
          if (remaining_q == 8'd0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            hldr_q  <= 1'b1;
            state_q <= S_REQ;
          end
        end
        default: begin
          hldr_q  <= 1'b0;
          ab_oe_q <= 1'b0;
          db_oe_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign AB        = ab_oe_q ? ab_q   : 8'bz;
  assign CB        = ab_oe_q ? cb_q   : 4'bz;
  assign DB        = db_oe_q ? data_q : 8'bz;
  assign HLDR      = hldr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: doc/dma_bus_master.md
Name: dma_bus_master

Overview:
- Requester side of the HLDR/HLDA bus-hold handshake used by the CPU.
- On a start command, asserts HLDR, waits for HLDA, then takes ownership of the shared 8-bit AB/DB and 4-bit CB buses.
- Copies a block of bytes from a source address to a destination address, one read cycle and one write cycle per byte.
- Releases the buses after a programmable burst or when the transfer completes.

Parameters:
- BURST_LEN, 4: bytes moved per grant before the bus is released and re-requested; 0 means unlimited.
- CB_READ, 4'b1010: control-bus code driven during a memory read cycle.
- CB_WRITE, 4'b1001: control-bus code driven during a memory write cycle.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- src_addr  in  8  first source byte address; latched on an accepted start.
- dst_addr  in  8  first destination byte address; latched on an accepted start.
- count  in  8  number of bytes to move; latched on an accepted start.
- HLDR  out  1  hold request to the CPU; registered.
- HLDA  in  1  hold acknowledge from the CPU.
- AB  inout  8  address bus; driven only in RD/WR, otherwise 8'bz.
- DB  inout  8  data bus; driven only in WR, otherwise 8'bz.
- CB  inout  4  control bus; driven only in RD/WR, otherwise 4'bz.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle completion pulse.
- remaining  out  8  bytes still to transfer.

Behaviour:
- Reset, applied at any time including mid-transfer:
  - state to IDLE; HLDR=0, busy=0, done=0, remaining=0.
  - AB/DB/CB go high-Z on the same edge.
  - Internal src/dst/data/burst registers cleared.
- States and transitions:
  - IDLE: start=1 with count!=0 → latch src, dst, count; remaining=count; busy=1; go to REQ.
  - IDLE: start=1 with count==0 → done=1 next cycle; busy stays 0; remain in IDLE.
  - REQ: HLDR=1; buses high-Z. HLDA=1 sampled → go to RD and clear burst counter. Otherwise stay in REQ (no timeout).
  - RD (one cycle): AB=src, CB=CB_READ, DB high-Z; data_reg<=DB at the closing edge.
    - HLDA=0 at that edge → read discarded, no counters change, go to REL.
    - Otherwise go to WR.
  - WR (one cycle): AB=dst, DB=data_reg, CB=CB_WRITE. At the closing edge: src+1, dst+1, remaining-1, burst+1.
    - Updated remaining==0 → REL.
    - Burst counter reaches BURST_LEN (when BURST_LEN!=0) → REL.
    - HLDA=0 → REL; the current write still completes.
    - Otherwise → RD.
  - REL (one cycle): HLDR=0; buses high-Z.
    - remaining==0 → IDLE with done=1 and busy=0 on the transition edge.
    - Otherwise → REQ.
- HLDR is asserted in REQ, RD and WR; it is 0 in IDLE and REL.
- Bus ownership:
  - AB/CB/DB are never driven outside RD/WR.
  - Per-byte latency once granted is 2 cycles.
  - A re-request always inserts at least one REL cycle with HLDR=0.
- Arithmetic: src and dst increment modulo 256 (0xFF wraps to 0x00); remaining never underflows.
- start while busy=1 is ignored, with no effect on latched values.
- done stays high exactly one cycle.

Test Plan:
- Basic copy, BURST_LEN=4: src=0x10, dst=0x40, count=3, HLDA tied high after HLDR, memory holds 0xA1/0xA2/0xA3 → bus shows RD 0x10, WR 0x40=0xA1, RD 0x11, WR 0x41=0xA2, RD 0x12, WR 0x42=0xA3; then REL, one done pulse, HLDR=0, buses high-Z. Total 1 REQ + 6 + 1 REL cycles after grant.
- Zero count: start with count=0 → HLDR never asserted; done pulses once; busy stays 0.
- Burst split, BURST_LEN=2, count=5 → three grant periods moving 2, 2 and 1 bytes, each separated by a REL cycle with HLDR=0; final remaining=0.
- Grant loss: HLDA drops during the RD of byte 2 of 4 → byte 2 is not written and remaining stays 3; bus released; after re-grant, byte 2 is re-read from the same src address.
- Wrap and busy: src=0xFE, dst=0xFF, count=3 → reads 0xFE, 0xFF, 0x00 and writes 0xFF, 0x00, 0x01. A start pulse mid-transfer with new values changes nothing.
- Reset mid-WR: reset=1 → next edge HLDR=0, buses high-Z, busy=0, remaining=0, no done pulse.
